// File: rtl/rush_hour_tracker.sv
// rush_hour_tracker: work-day timebase plus first-rush-hour capture.
// The timebase divides clk into seconds and hours and saturates at the last
// work hour. A three-state FSM watches the lot's full/empty levels, and two
// capture registers latch the hour at which the first rush of the day starts
// and ends. work_day_increment restarts everything for a new day.
//
// Handshake: there are no valid/ready pairs. rush_start_valid and
// rush_end_valid are internal one-cycle strobes, combinational from the
// current state and inputs. They are consumed unconditionally by the capture
// registers on the same clock edge.
module rush_hour_tracker #(
  parameter int CNT_1S    = 50_000_000,
  parameter int CNT_HOUR  = 3600,
  parameter int NUM_HOURS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       work_day_increment,
  input  logic       slot_empty,
  input  logic       slot_full,
  output logic [3:0] work_hour,
  output logic       expired_one_second,
  output logic       expired_one_hour,
  output logic       work_day_expired,
  output logic       rush_start_exist,
  output logic [3:0] rush_start,
  output logic       rush_end_exist,
  output logic [3:0] rush_end
);

  localparam int CW = (CNT_1S > 1) ? $clog2(CNT_1S) : 1;
  localparam int SW = (CNT_HOUR > 1) ? $clog2(CNT_HOUR) : 1;
  localparam logic [CW-1:0] CYC_LAST  = CW'(CNT_1S - 1);
  localparam logic [SW-1:0] SEC_LAST  = SW'(CNT_HOUR - 1);
  localparam logic [3:0]    HOUR_LAST = 4'(NUM_HOURS - 1);

  localparam logic [1:0] S_WAIT_FULL  = 2'd0;
  localparam logic [1:0] S_WAIT_EMPTY = 2'd1;
  localparam logic [1:0] S_DONE       = 2'd2;

  logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [SW-1:0] sec_cnt_q, sec_cnt_d;
  logic [3:0]    work_hour_q, work_hour_d;
  logic          expired_q, expired_d;
  logic [1:0]    state_q, state_d;
  logic          rush_start_exist_q, rush_start_exist_d;
  logic [3:0]    rush_start_q, rush_start_d;
  logic          rush_end_exist_q, rush_end_exist_d;
  logic [3:0]    rush_end_q, rush_end_d;

  logic sec_tick;
  logic hour_tick;
  logic rush_start_valid;
  logic rush_end_valid;

  // Timebase: second/hour ticks and next counter values; frozen once the day expires.
  always_comb begin
    sec_tick    = !expired_q && (cyc_cnt_q == CYC_LAST);
    hour_tick   = sec_tick && (sec_cnt_q == SEC_LAST);
    cyc_cnt_d   = cyc_cnt_q;
    sec_cnt_d   = sec_cnt_q;
    work_hour_d = work_hour_q;
    expired_d   = expired_q;
    if (work_day_increment) begin
      cyc_cnt_d   = '0;
      sec_cnt_d   = '0;
      work_hour_d = '0;
      expired_d   = 1'b0;
    end else if (expired_q) begin
      cyc_cnt_d = '0;
      sec_cnt_d = '0;
    end else begin
      cyc_cnt_d = sec_tick ? '0 : cyc_cnt_q + CW'(1);
      if (sec_tick) begin
        sec_cnt_d = hour_tick ? '0 : sec_cnt_q + SW'(1);
      end
      if (hour_tick) begin
        if (work_hour_q == HOUR_LAST) begin
          expired_d = 1'b1;
        end else begin
          work_hour_d = work_hour_q + 4'd1;
        end
      end
    end
  end

  // Control FSM: first full, then first genuine empty, then ignore the rest of the day.
  always_comb begin
    state_d          = state_q;
    rush_start_valid = 1'b0;
    rush_end_valid   = 1'b0;
    case (state_q)
      S_WAIT_FULL: begin
        // Both levels high is treated as full here.
        if (slot_full && !expired_q) begin
          rush_start_valid = 1'b1;
          state_d          = S_WAIT_EMPTY;
        end
      end
      S_WAIT_EMPTY: begin
        // Both levels high is not an empty lot.
        if (slot_empty && !slot_full && !expired_q) begin
          rush_end_valid = 1'b1;
          state_d        = S_DONE;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_WAIT_FULL;
    endcase
    if (work_day_increment) begin
      state_d = S_WAIT_FULL;
    end
  end

  // Datapath: latch the hour seen before the capturing edge; a new day clears everything.
  always_comb begin
    rush_start_exist_d = rush_start_exist_q;
    rush_start_d       = rush_start_q;
    rush_end_exist_d   = rush_end_exist_q;
    rush_end_d         = rush_end_q;
    if (work_day_increment) begin
      rush_start_exist_d = 1'b0;
      rush_start_d       = '0;
      rush_end_exist_d   = 1'b0;
      rush_end_d         = '0;
    end else begin
      if (rush_start_valid) begin
        rush_start_exist_d = 1'b1;
        rush_start_d       = work_hour_q;
      end
      if (rush_end_valid) begin
        rush_end_exist_d = 1'b1;
        rush_end_d       = work_hour_q;
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt_q          <= '0;
      sec_cnt_q          <= '0;
      work_hour_q        <= '0;
      expired_q          <= 1'b0;
      state_q            <= S_WAIT_FULL;
      rush_start_exist_q <= 1'b0;
      rush_start_q       <= '0;
      rush_end_exist_q   <= 1'b0;
      rush_end_q         <= '0;
    end else begin
      cyc_cnt_q          <= cyc_cnt_d;
      sec_cnt_q          <= sec_cnt_d;
      work_hour_q        <= work_hour_d;
      expired_q          <= expired_d;
      state_q            <= state_d;
      rush_start_exist_q <= rush_start_exist_d;
      rush_start_q       <= rush_start_d;
      rush_end_exist_q   <= rush_end_exist_d;
      rush_end_q         <= rush_end_d;
    end
  end

  assign work_hour          = work_hour_q;
  assign expired_one_second = sec_tick;
  assign expired_one_hour   = hour_tick;
  assign work_day_expired   = expired_q;
  assign rush_start_exist   = rush_start_exist_q;
  assign rush_start         = rush_start_q;
  assign rush_end_exist     = rush_end_exist_q;
  assign rush_end           = rush_end_q;

endmodule

// File: tb/tb_rush_hour_tracker.sv
// Bench for rush_hour_tracker with a 5-cycle second and a 5-second hour.
// The timebase is checked every cycle against a closed-form model of k,
// the number of clock edges since release or since the last new-day pulse.
// Rush capture is checked from a vector table plus hand-written sequences.
module tb_rush_hour_tracker;

  localparam int CNT_1S    = 5;
  localparam int CNT_HOUR  = 5;
  localparam int NUM_HOURS = 8;
  localparam int HOUR_CYC  = CNT_1S * CNT_HOUR;
  localparam int DAY_CYC   = HOUR_CYC * NUM_HOURS;

  logic       clk;
  logic       reset;
  logic       work_day_increment;
  logic       slot_empty;
  logic       slot_full;
  logic [3:0] work_hour;
  logic       expired_one_second;
  logic       expired_one_hour;
  logic       work_day_expired;
  logic       rush_start_exist;
  logic [3:0] rush_start;
  logic       rush_end_exist;
  logic [3:0] rush_end;

  int tests_run;
  int tests_failed;
  int k;

  typedef struct {
    int         n;
    logic       full;
    logic       empty;
    logic       rs_ex;
    logic [3:0] rs;
    logic       re_ex;
    logic [3:0] re;
  } vec_t;

  vec_t vecs[13];

  rush_hour_tracker #(
    .CNT_1S(CNT_1S), .CNT_HOUR(CNT_HOUR), .NUM_HOURS(NUM_HOURS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .work_day_increment(work_day_increment),
    .slot_empty(slot_empty),
    .slot_full(slot_full),
    .work_hour(work_hour),
    .expired_one_second(expired_one_second),
    .expired_one_hour(expired_one_hour),
    .work_day_expired(work_day_expired),
    .rush_start_exist(rush_start_exist),
    .rush_start(rush_start),
    .rush_end_exist(rush_end_exist),
    .rush_end(rush_end)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s (k=%0d): got %0h expected %0h", name, k, act, exp);
    end
  endtask

  // Timebase expectation as a function of edges since the start of the day.
  task automatic check_timebase();
    logic       ex;
    logic [3:0] h;
    ex = (k >= DAY_CYC);
    h  = ex ? 4'(NUM_HOURS - 1) : 4'(k / HOUR_CYC);
    check("work_hour", 8'(work_hour), 8'(h));
    check("work_day_expired", 8'(work_day_expired), 8'(ex));
    check("expired_one_second", 8'(expired_one_second), 8'(!ex && (k % CNT_1S == CNT_1S - 1)));
    check("expired_one_hour", 8'(expired_one_hour), 8'(!ex && (k % HOUR_CYC == HOUR_CYC - 1)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (work_day_increment) k = 0;
    else k++;
    check_timebase();
  endtask

  task automatic check_rush(input string tag, input logic rs_ex, input logic [3:0] rs,
                            input logic re_ex, input logic [3:0] re);
    check({tag, ".rush_start_exist"}, 8'(rush_start_exist), 8'(rs_ex));
    check({tag, ".rush_start"}, 8'(rush_start), 8'(rs));
    check({tag, ".rush_end_exist"}, 8'(rush_end_exist), 8'(re_ex));
    check({tag, ".rush_end"}, 8'(rush_end), 8'(re));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".work_hour"}, 8'(work_hour), 8'h0);
    check({tag, ".pulses"}, 8'({expired_one_second, expired_one_hour}), 8'h0);
    check({tag, ".work_day_expired"}, 8'(work_day_expired), 8'h0);
    check_rush(tag, 1'b0, 4'd0, 1'b0, 4'd0);
  endtask

  initial begin
    tests_run          = 0;
    tests_failed       = 0;
    k                  = 0;
    reset              = 1'b0;
    work_day_increment = 1'b0;
    slot_empty         = 1'b1;
    slot_full          = 1'b0;

    // n, full, empty, rush_start_exist, rush_start, rush_end_exist, rush_end
    vecs[0]  = '{60, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0};  // quiet lot, hours 0..2
    vecs[1]  = '{3,  1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0};  // empty/non-empty toggling
    vecs[2]  = '{3,  1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0};
    vecs[3]  = '{14, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0};  // k=80, inside hour 3
    vecs[4]  = '{1,  1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0};  // first full -> start=3
    vecs[5]  = '{24, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0};  // into hour 4
    vecs[6]  = '{5,  1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0};  // second full ignored
    vecs[7]  = '{43, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0};  // k=153, hour 6
    vecs[8]  = '{2,  1'b1, 1'b1, 1'b1, 4'd3, 1'b0, 4'd0};  // both high: not empty
    vecs[9]  = '{1,  1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 4'd6};  // first empty -> end=6
    vecs[10] = '{4,  1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 4'd6};  // later activity ignored
    vecs[11] = '{4,  1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 4'd6};
    vecs[12] = '{36, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 4'd6};  // k=200, day expired

    // Reset held 25 cycles: every output stays 0.
    repeat (25) begin
      @(posedge clk);
      #1;
      check_all_zero("in_reset");
    end
    reset = 1'b1;
    k     = 0;

    // Table-driven first day.
    for (int i = 0; i < 13; i++) begin
      slot_full  = vecs[i].full;
      slot_empty = vecs[i].empty;
      repeat (vecs[i].n) tick();
      check_rush($sformatf("vec%0d", i), vecs[i].rs_ex, vecs[i].rs, vecs[i].re_ex, vecs[i].re);
    end

    // New day: capture start and end on consecutive cycles in hour 0.
    slot_full          = 1'b0;
    slot_empty         = 1'b1;
    work_day_increment = 1'b1;
    tick();
    work_day_increment = 1'b0;
    check_rush("newday", 1'b0, 4'd0, 1'b0, 4'd0);
    slot_full  = 1'b1;
    slot_empty = 1'b0;
    tick();
    check_rush("start_h0", 1'b1, 4'd0, 1'b0, 4'd0);
    slot_full  = 1'b0;
    slot_empty = 1'b1;
    tick();
    check_rush("end_next", 1'b1, 4'd0, 1'b1, 4'd0);
    repeat (30) tick();

    // Mid-day new-day pulse coinciding with a full event: the clear wins.
    slot_full          = 1'b1;
    slot_empty         = 1'b0;
    work_day_increment = 1'b1;
    tick();
    work_day_increment = 1'b0;
    slot_full          = 1'b0;
    slot_empty         = 1'b1;
    check_rush("midday_clear", 1'b0, 4'd0, 1'b0, 4'd0);

    // Full after the day expires is not recorded.
    repeat (DAY_CYC) tick();
    slot_full  = 1'b1;
    slot_empty = 1'b0;
    repeat (5) tick();
    check_rush("after_expiry", 1'b0, 4'd0, 1'b0, 4'd0);

    // Both high on the hour-boundary cycle: counts as full, captures the old hour.
    slot_full          = 1'b0;
    slot_empty         = 1'b1;
    work_day_increment = 1'b1;
    tick();
    work_day_increment = 1'b0;
    repeat (HOUR_CYC - 1) tick();
    slot_full = 1'b1;
    tick();
    check_rush("start_on_boundary", 1'b1, 4'd0, 1'b0, 4'd0);
    slot_full = 1'b0;
    repeat (12) tick();
    check_rush("end_h1", 1'b1, 4'd0, 1'b1, 4'd1);

    // Asynchronous reset mid-hour clears outputs before the next edge.
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rush_hour_tracker.md
# rush_hour_tracker

Parking-lot rush-hour tracker for a single work day. An hour timebase (`hour_count`) divides the system clock into seconds and hours and produces the current work hour. A control FSM (`control`) watches the lot's full/empty status. A datapath (`datapath`) latches the work hour at which the first rush hour starts and ends. The block sits between the lot occupancy logic, which supplies `slot_empty`/`slot_full`, and the display/report logic, which consumes the rush hour outputs.

## Interface
Parameters:
- `CNT_1S`, default 50_000_000: clock cycles per second; must be ≥ 2.
- `CNT_HOUR`, default 3600: seconds per work hour; must be ≥ 1.
- `NUM_HOURS`, default 8: work hours per day, 1..16.

Ports:
- `clk`  in  1  sole clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `work_day_increment`  in  1  one-cycle pulse that starts a new day.
- `slot_empty`  in  1  lot has no cars, level.
- `slot_full`  in  1  lot has no free slot, level.
- `work_hour`  out  4  current hour of day, 0..NUM_HOURS-1.
- `expired_one_second`  out  1  one-cycle pulse at each second boundary.
- `expired_one_hour`  out  1  one-cycle pulse at each hour boundary.
- `work_day_expired`  out  1  level, day finished.
- `rush_start_exist`  out  1  `rush_start` is valid.
- `rush_start`  out  4  hour at which the lot first became full.
- `rush_end_exist`  out  1  `rush_end` is valid.
- `rush_end`  out  4  hour at which the lot first became empty after `rush_start`.

## Operation
- Timebase:
  - `cyc_cnt` counts 0..CNT_1S-1. At CNT_1S-1 it wraps and pulses `expired_one_second`.
  - On each second pulse, `sec_cnt` counts 0..CNT_HOUR-1. When it wraps it pulses `expired_one_hour`, in the same cycle as the second pulse.
  - On each hour pulse, `work_hour` increments. If `work_hour` = NUM_HOURS-1, it holds that value instead and `work_day_expired` is set.
  - While `work_day_expired`=1: counters are frozen at 0 and no pulses are generated.
- Control FSM (3 states):
  - WAIT_FULL (reset state):
    - If `slot_full`=1 and day not expired, assert `rush_start_valid` (combinational, one cycle) and go to WAIT_EMPTY.
  - WAIT_EMPTY:
    - If `slot_empty`=1 and `slot_full`=0 and day not expired, assert `rush_end_valid` and go to DONE.
  - DONE: absorbing state; all further `slot_*` activity is ignored for the rest of the day.
- Datapath:
  - On `rush_start_valid`: `rush_start`<=`work_hour` and `rush_start_exist`<=1.
  - On `rush_end_valid`: `rush_end`<=`work_hour` and `rush_end_exist`<=1.
  - Registers hold until reset or a new day. Only the first rush of a day is recorded.
- `work_day_increment`=1 (synchronous, highest priority after reset) has these effects:
  - Counters go to 0, `work_hour` goes to 0, `work_day_expired` goes to 0.
  - FSM goes to WAIT_FULL.
  - All rush outputs are cleared.
- Both `slot_full` and `slot_empty` high (illegal) has these effects:
  - In WAIT_FULL, it counts as full.
  - In WAIT_EMPTY, it does not count as empty.

## Timing
- Reset asserted (`reset`=0) forces all outputs and state to 0 and the FSM to WAIT_FULL, asynchronously.
- Start of day: the first `expired_one_second` pulse occurs CNT_1S cycles after reset release.
- Hour boundary: `work_hour` changes on the same edge that ends the `expired_one_hour` pulse.
  - `work_hour`=k+1 is visible CNT_1S·CNT_HOUR cycles after `work_hour`=k appeared.
- Rush capture latency is 1 cycle:
  - The condition is sampled at edge N, capturing the `work_hour` value present before edge N.
  - The exist flag and hour value are visible after edge N.
- A start event in the same cycle as an hour increment captures the old hour.
- No end capture is possible in the same cycle as the start capture; the earliest end is the following cycle.
- `work_day_increment` coinciding with a tick or a rush event: the new-day clear wins.

## Test plan
Use CNT_1S=5, CNT_HOUR=5, NUM_HOURS=8, so one hour is 25 cycles.
- Reset held 25 cycles, then released, `slot_empty`=1, `slot_full`=0:
  - All outputs are 0 during reset.
  - `expired_one_second` pulses every 5 cycles after release.
  - `work_hour` increments every 25 cycles.
  - Both exist flags stay 0.
- Lot toggles empty/non-empty without ever becoming full → no rush start or end recorded.
- `slot_full` rises during hour 3, drops, then rises again in hour 4:
  - `rush_start`=3 and `rush_start_exist`=1 one cycle after the first rise.
  - The value is unchanged by the second rise.
- After the start, `slot_empty` rises in hour 6:
  - `rush_end`=6 and `rush_end_exist`=1.
  - Later full/empty cycles change nothing.
- Run 8·25 cycles:
  - `work_hour` saturates at 7 and `work_day_expired`=1.
  - `slot_full` asserted after that is not recorded.
- Pulse `work_day_increment` mid-day with rushes recorded:
  - Next cycle: `work_hour`=0 and all rush outputs are 0.
- Assert reset mid-hour: outputs clear asynchronously, before the next clock edge.
